// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus dispatcher.
// Holds the dispatcher state encoding, the number of slave ports and the
// symbolic indices of each slave on the 2-bit port-select field.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NPORT = 4;

  localparam logic [1:0] PORT_RAM   = 2'd0;
  localparam logic [1:0] PORT_UART  = 2'd1;
  localparam logic [1:0] PORT_TIMER = 2'd2;
  localparam logic [1:0] PORT_GPIO  = 2'd3;

endpackage

// File: rtl/MUX4.sv
// Four-input multiplexer library cell.
// Ports:
//   i_sel        2-bit select
//   i_d0..i_d3   data inputs, WIDTH bits each
//   o_y          selected data
module MUX4 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/bus_timeout_cnt.sv
// 8-bit wait-cycle counter used to detect a slave that never answers.
// Ports:
//   i_clk      clock, rising edge
//   i_rstn     synchronous active-low reset
//   i_clr      clear the count to zero (has priority over i_en)
//   i_en       increment the count
//   o_expired  high while the count equals LIMIT
module bus_timeout_cnt #(
  parameter logic [7:0] LIMIT = 8'd15
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/bus_dispatch.sv
// Routes one CPU data-memory access at a time to one of four peripheral
// slaves (RAM, UART, timer, GPIO) selected by a 2-bit address field, holds
// the request/ready handshake with that slave and returns its read data.
// A wait-cycle counter ends the access with an error if the slave stalls.
// Ports:
//   clk, rstn            clock and synchronous active-low reset
//   m_req/m_we/m_addr/m_wdata   CPU request side
//   m_ready/m_rdata/m_err       CPU completion pulse, read data, error flag
//   s_req                one-hot slave request
//   s_we/s_addr/s_wdata  registered request payload towards the slaves
//   s_ready/s_rdata      per-slave ready and packed read data
module bus_dispatch
  import bus_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               SEL_LSB = 12,
  parameter int               TIMEOUT = 16,
  parameter logic [NPORT-1:0] PORT_EN = 4'b1111
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   m_req,
  input  logic                   m_we,
  input  logic [31:0]            m_addr,
  input  logic [WIDTH-1:0]       m_wdata,
  output logic                   m_ready,
  output logic [WIDTH-1:0]       m_rdata,
  output logic                   m_err,
  output logic [NPORT-1:0]       s_req,
  output logic                   s_we,
  output logic [31:0]            s_addr,
  output logic [WIDTH-1:0]       s_wdata,
  input  logic [NPORT-1:0]       s_ready,
  input  logic [NPORT*WIDTH-1:0] s_rdata
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         w_idx;
  logic [1:0]         r_idx;
  logic               w_port_ok;
  logic               w_busy;
  logic               w_sel_ready;
  logic               w_expired;
  logic [WIDTH-1:0]   w_sel_rdata;
  logic [NPORT-1:0]   r_s_req;
  logic               r_s_we;
  logic [31:0]        r_s_addr;
  logic [WIDTH-1:0]   r_s_wdata;
  logic [WIDTH-1:0]   r_m_rdata;
  logic               r_m_err;

  assign w_idx       = m_addr[SEL_LSB+1:SEL_LSB];
  assign w_port_ok   = PORT_EN[w_idx];
  assign w_busy      = (r_state == BUSY);
  // Only the latched port's ready matters; other bits are distractors.
  assign w_sel_ready = s_ready[r_idx];

  MUX4 #(.WIDTH(WIDTH)) u_rdata_mux (
    .i_sel (r_idx),
    .i_d0  (s_rdata[0*WIDTH +: WIDTH]),
    .i_d1  (s_rdata[1*WIDTH +: WIDTH]),
    .i_d2  (s_rdata[2*WIDTH +: WIDTH]),
    .i_d3  (s_rdata[3*WIDTH +: WIDTH]),
    .o_y   (w_sel_rdata)
  );

  // Count is 0 in the first BUSY cycle, so hitting TIMEOUT-1 means the
  // slave has been waited on for TIMEOUT cycles.
  bus_timeout_cnt #(.LIMIT(8'(TIMEOUT - 1))) u_timeout (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_clr     (!w_busy),
    .i_en      (w_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (m_req) w_state_nxt = w_port_ok ? BUSY : DONE;
      BUSY: if (w_sel_ready || w_expired) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idx     <= 2'd0;
      r_s_req   <= '0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_m_rdata <= '0;
      r_m_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m_req) begin
            r_idx     <= w_idx;
            r_s_we    <= m_we;
            r_s_addr  <= m_addr;
            r_s_wdata <= m_wdata;
            if (w_port_ok) begin
              r_s_req <= NPORT'(1) << w_idx;
            end else begin
              r_m_rdata <= '0;
              r_m_err   <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Ready has priority over a timeout in the same cycle.
          if (w_sel_ready) begin
            r_m_rdata <= w_sel_rdata;
            r_m_err   <= 1'b0;
            r_s_req   <= '0;
          end else if (w_expired) begin
            r_m_rdata <= '0;
            r_m_err   <= 1'b1;
            r_s_req   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_ready = (r_state == DONE);
  assign m_rdata = r_m_rdata;
  assign m_err   = r_m_err;
  assign s_req   = r_s_req;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;

endmodule

// File: tb/tb_bus_dispatch.sv
// Scoreboard bench for bus_dispatch: the driver plays CPU and slaves and
// pushes the expected completion (data, error, cycle) predicted from the
// routing/timeout rules; a monitor pops and compares on every m_ready.
module tb_bus_dispatch;

  localparam int         W   = 32;
  localparam int         TO  = 16;
  localparam logic [3:0] PEN = 4'b0111;

  logic           clk = 1'b0;
  logic           rstn;
  logic           m_req;
  logic           m_we;
  logic [31:0]    m_addr;
  logic [W-1:0]   m_wdata;
  logic           m_ready;
  logic [W-1:0]   m_rdata;
  logic           m_err;
  logic [3:0]     s_req;
  logic           s_we;
  logic [31:0]    s_addr;
  logic [W-1:0]   s_wdata;
  logic [3:0]     s_ready;
  logic [4*W-1:0] s_rdata;

  bus_dispatch #(
    .WIDTH(W), .SEL_LSB(12), .TIMEOUT(TO), .PORT_EN(PEN)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_m_ready: got m_ready=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("m_rdata", m_rdata, e_mon.rdata);
        chk("m_err", m_err, e_mon.err);
        chk("m_ready_cycle", cyc, e_mon.done_cyc);
      end
    end
  end

  // One transaction. delay = wait cycles before the slave raises ready
  // (ready appears in cycle delay+1). noise forces all other ready bits high.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [W-1:0] wdata,
                         input logic [W-1:0] srd, input int delay, input bit noise);
    exp_t       e;
    int         lat;
    int         k;
    bit         done;
    logic [1:0] port;
    logic [3:0] exp_req;
    port    = addr[13:12];
    exp_req = 4'b0001 << port;
    @(posedge clk); #1;
    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    s_ready = 4'b0000;
    @(posedge clk); #1;
    // Reference model: disabled port, answered in time, or timed out.
    if (!PEN[port]) begin
      e.rdata = '0; e.err = 1'b1; lat = 1;
    end else if (delay + 1 <= TO) begin
      e.rdata = srd; e.err = 1'b0; lat = delay + 2;
    end else begin
      e.rdata = '0; e.err = 1'b1; lat = TO + 1;
    end
    e.done_cyc = cyc + lat - 1;
    sb.push_back(e);
    // Request payload is latched, so the CPU-side bus may now wander.
    m_we    = $urandom_range(0, 1);
    m_addr  = $urandom;
    m_wdata = $urandom;
    done = 1'b0;
    k    = 1;
    while (!done && k <= TO + 4) begin
      if (m_ready) begin
        chk("s_req_done", s_req, 4'b0000);
        s_ready = 4'b0000;
        done    = 1'b1;
      end else begin
        chk("s_req_busy", s_req, exp_req);
        chk("s_payload", {s_we, s_addr, s_wdata}, {we, addr, wdata});
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        s_rdata[port*W +: W] = srd;
        s_ready = noise ? 4'b1111 : 4'($urandom_range(0, 15));
        s_ready[port] = (k == delay + 1);
        @(posedge clk); #1;
        k++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL no_m_ready: got no completion expected one within %0d cycles", TO + 4);
    end
    // m_req still high across the DONE edge: it must not start a new access.
    @(posedge clk); #1;
    m_req = 1'b0;
    chk("s_req_after_done", s_req, 4'b0000);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {s_req, s_we, s_addr, s_wdata, m_ready, m_err, m_rdata}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         r;
    int         d;
    logic [31:0] a;
    rstn    = 1'b0;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    s_ready = '0;
    s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rstn = 1'b1;

    // Read port 0, slave ready in cycle 1.
    run_txn(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b0);
    // Write port 2, three wait cycles.
    run_txn(1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3, 1'b0);
    // Port 1 timeout with ready stuck low.
    run_txn(1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 255, 1'b0);
    // Ready on the expiry cycle wins.
    run_txn(1'b0, 32'h0000_1008, 32'h0, 32'hCAFE_0001, TO - 1, 1'b0);
    // Ready one cycle too late.
    run_txn(1'b0, 32'h0000_100C, 32'h0, 32'hCAFE_0002, TO, 1'b0);
    // Disabled port 3.
    run_txn(1'b0, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 0, 1'b0);
    // Distractor ready bits on the other ports while port 0 waits.
    run_txn(1'b0, 32'h0000_0040, 32'h0, 32'h7777_8888, 5, 1'b1);

    // Reset in the middle of a BUSY access.
    @(posedge clk); #1;
    m_req  = 1'b1;
    m_we   = 1'b1;
    m_addr = 32'h0000_0100;
    s_ready = 4'b0000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rstn  = 1'b0;
    m_req = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_mid_txn");
    rstn = 1'b1;
    run_txn(1'b0, 32'h0000_0020, 32'h0, 32'h0F0F_0F0F, 1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      d = $urandom_range(0, 4);
      else if (r < 8) d = $urandom_range(TO - 2, TO);
      else            d = 255;
      a = $urandom;
      run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom, d, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_dispatch.md
# bus_dispatch

Routes single data-memory access transactions from the CPU to one of four peripheral slaves: RAM, UART, timer and GPIO. It performs the one-to-many direction of the datapath mux library. The target slave is chosen from an address field. The block holds a request/ready handshake with the selected slave and returns that slave's read data to the CPU. A timeout counter reports an error if a slave never answers. It sits between the SCPU data-memory port and the peripheral bus.

## Interface
Parameters:
- WIDTH, 32, data width
- SEL_LSB, 12, low bit of the 2-bit port-select field in the address
- TIMEOUT, 16, maximum BUSY cycles before error; legal range 2..255
- PORT_EN, 4'b1111, per-port enable mask

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous, active-low reset
- m_req  in  1  CPU request; held until m_ready
- m_we  in  1  1 = write, 0 = read
- m_addr  in  32  byte address
- m_wdata  in  WIDTH  write data
- m_ready  out  1  one-cycle completion pulse
- m_rdata  out  WIDTH  read data, valid while m_ready=1
- m_err  out  1  error flag, valid while m_ready=1
- s_req  out  4  one-hot slave request
- s_we  out  1  registered copy of m_we
- s_addr  out  32  registered copy of m_addr
- s_wdata  out  WIDTH  registered copy of m_wdata
- s_ready  in  4  per-slave ready
- s_rdata  in  4*WIDTH  slave i read data in bits [i*WIDTH +: WIDTH]

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - On m_req=1, latch we, addr and wdata into the s_* registers.
  - Latch idx = m_addr[SEL_LSB+1:SEL_LSB].
  - If PORT_EN[idx]=1, go to BUSY with s_req=1<<idx.
  - Otherwise go to DONE with err=1 and rdata=0; no s_req is issued.
- BUSY:
  - s_req[idx] stays high and the timeout counter increments.
  - s_ready[idx]=1: capture s_rdata slice idx into m_rdata, set err=0, clear s_req, go to DONE.
  - Counter reaches TIMEOUT-1 with no ready: set rdata=0, err=1, clear s_req, go to DONE.
  - Ready in the same cycle as timeout: ready wins, err=0.
- DONE:
  - m_ready=1 for exactly one cycle, then go to IDLE.
  - m_req is ignored in DONE.
- s_ready bits of non-selected ports are ignored in every state. s_ready is ignored outside BUSY.
- Writes return m_rdata as the captured slice. The CPU ignores it.
- m_rdata and m_err hold their values until the next DONE. The CPU samples them only while m_ready=1.

## Timing
- Reset (rstn=0 at a clock edge) forces the following, overriding any in-flight transaction:
  - state=IDLE, counter=0
  - s_req=0, s_we=0, s_addr=0, s_wdata=0
  - m_ready=0, m_err=0, m_rdata=0
- An aborted slave access is simply dropped.
- m_req is sampled at edge 0. s_req is high in cycle 1.
- If s_ready is sampled high at edge k, m_ready is high in cycle k+1. Minimum latency is 2 cycles (slave ready in cycle 1).
- A disabled port gives m_ready in cycle 1 with m_err=1.
- Timeout gives m_ready in cycle TIMEOUT+1 with m_err=1.
- Back-to-back transactions: a new m_req is accepted at the earliest in the IDLE cycle after DONE, so throughput is at most one transaction per 3 cycles.
- s_* address, data and write-enable outputs are stable from the cycle s_req rises until DONE.

## Structure
- Shared package bus_pkg holds:
  - the state enum (IDLE, BUSY, DONE)
  - NPORT=4
  - port index constants (RAM=0, UART=1, TIMER=2, GPIO=3)
- Read-data return select uses the existing MUX4 library cell, with WIDTH passed through.
- One sub-module, bus_timeout_cnt: an 8-bit counter with clear and enable inputs and an expired output.

## Test plan
- Read port 0: m_addr=0x0000_0010, slave 0 ready in cycle 1 with s_rdata=0x1234_5678 -> m_ready in cycle 2, m_rdata=0x1234_5678, m_err=0, s_req=4'b0001 only during cycle 1.
- Write port 2: m_addr=0x0000_2004, m_wdata=0xA5A5_A5A5, slave 2 ready after 3 wait cycles -> s_req=4'b0100 held 4 cycles, s_wdata=0xA5A5_A5A5, s_we=1, m_ready in cycle 5, m_err=0.
- Timeout on port 1 with s_ready stuck at 0 and TIMEOUT=16 -> m_ready in cycle 17, m_err=1, m_rdata=0. Variant: ready arrives on the expiry cycle -> m_err=0.
- PORT_EN=4'b0111 and an access to port 3 -> no s_req issued, m_ready in cycle 1, m_err=1.
- Distractors: s_ready=4'b1110 asserted while port 0 is BUSY -> no completion until s_ready[0]=1.
- Reset mid-transaction: rstn=0 during BUSY -> next cycle all outputs are 0 and state is IDLE. A new read afterwards completes normally.
